gpr_wb_arbiter: RTL and testbench

//  Sequences the single write port of the 32x32 GPR file. Arbitrates two writeback

---
 rtl/gpr_wb_arbiter.sv | 173 +++++++++++++++++
 tb/tb_gpr_wb_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : gpr_wb_arbiter
//  Purpose  : Sequences the single write port of the GPR file. Two writeback
//             requesters (EXU = req0, LSU = req1) are arbitrated round-robin
//             with valid/ready handshakes. The winner is registered onto the
//             regfile write port (wb_wen/wb_addr/wb_data). A per-register
//             pending scoreboard lets decode stall on RAW hazards.
//  Ports    : clk, rst (asynchronous, active-low)
//             iss_valid/iss_rd            - decode issue, marks rd pending
//             req0_valid/rd/data/ready    - EXU writeback handshake
//             req1_valid/rd/data/ready    - LSU writeback handshake
//             wb_wen/wb_addr/wb_data      - registered regfile write port
//             rs1_addr/rs2_addr           - decode source lookups
//             rs1_busy/rs2_busy           - source has a pending write
//  Config   : GPR_WB_EARLY_CLEAR_EN - when defined, a register being written
//             this cycle reads as not busy (unless re-issued this cycle).
//  Revision : 1.0 - initial release
// ============================================================================
module gpr_wb_arbiter #(
   parameter int DW    = 32,
   parameter int AW    = 5,
   parameter int NREGS = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          iss_valid,
   input  logic [AW-1:0] iss_rd,
   input  logic          req0_valid,
   input  logic [AW-1:0] req0_rd,
   input  logic [DW-1:0] req0_data,
   output logic          req0_ready,
   input  logic          req1_valid,
   input  logic [AW-1:0] req1_rd,
   input  logic [DW-1:0] req1_data,
   output logic          req1_ready,
   output logic          wb_wen,
   output logic [AW-1:0] wb_addr,
   output logic [DW-1:0] wb_data,
   input  logic [AW-1:0] rs1_addr,
   input  logic [AW-1:0] rs2_addr,
   output logic          rs1_busy,
   output logic          rs2_busy
);

   // rr_last resets to 1 so that req0 wins the first contended cycle.
   localparam logic c_RR_INIT = 1'b1;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic             r_rr_last;
   logic             r_wb_wen;
   logic [AW-1:0]    r_wb_addr;
   logic [DW-1:0]    r_wb_data;
   logic [NREGS-1:0] r_sb;

   // ------------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------------
   logic             w_grant0;
   logic             w_grant1;
   logic             w_fire;
   logic [AW-1:0]    w_win_rd;
   logic [DW-1:0]    w_win_data;
   logic             w_iss_set;
   logic [NREGS-1:0] w_set_mask;
   logic [NREGS-1:0] w_clr_mask;
   logic [NREGS-1:0] w_sb_next;
   logic             w_rs1_busy;
   logic             w_rs2_busy;

   // ------------------------------------------------------------------------
   // Round-robin arbitration. A lone requester always wins; under contention
   // the requester that did not win last time is granted. A grant is only
   // ever given to a valid requester, so grant itself is the fire condition.
   // ------------------------------------------------------------------------
   always_comb begin
      w_grant0 = req0_valid && (!req1_valid || r_rr_last);
      w_grant1 = req1_valid && (!req0_valid || !r_rr_last);
   end

   assign w_fire     = w_grant0 || w_grant1;
   assign w_win_rd   = w_grant1 ? req1_rd   : req0_rd;
   assign w_win_data = w_grant1 ? req1_data : req0_data;

   assign req0_ready = w_grant0;
   assign req1_ready = w_grant1;

   // Last-winner pointer: only moves on an accepted request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rr_last <= c_RR_INIT;
      end else if (w_fire) begin
         r_rr_last <= w_grant1;
      end
   end

   // ------------------------------------------------------------------------
   // Write stage (latency 1). Writes to x0 are accepted but never raise the
   // enable; address/data still follow the accepted request.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wb_wen  <= 1'b0;
         r_wb_addr <= '0;
         r_wb_data <= '0;
      end else if (w_fire) begin
         r_wb_wen  <= (w_win_rd != '0);
         r_wb_addr <= w_win_rd;
         r_wb_data <= w_win_data;
      end else begin
         r_wb_wen  <= 1'b0;
      end
   end

   assign wb_wen  = r_wb_wen;
   assign wb_addr = r_wb_addr;
   assign wb_data = r_wb_data;

   // ------------------------------------------------------------------------
   // Pending-write scoreboard. Clear comes from the write-stage cycle; a set
   // of the same register in that cycle wins because it represents a newer
   // producer that is still outstanding. Bit 0 is never set.
   // ------------------------------------------------------------------------
   assign w_iss_set = iss_valid && (iss_rd != '0);

   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      if (w_iss_set) begin
         w_set_mask[iss_rd] = 1'b1;
      end
      if (r_wb_wen) begin
         w_clr_mask[r_wb_addr] = 1'b1;
      end
      w_sb_next    = (r_sb & ~w_clr_mask) | w_set_mask;
      w_sb_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sb <= '0;
      end else begin
         r_sb <= w_sb_next;
      end
   end

   // ------------------------------------------------------------------------
   // Source busy lookups. With early clear, a register whose write is on the
   // port this cycle is visible to decode at the next edge, so it need not
   // stall -- unless decode is re-issuing the same destination right now.
   // ------------------------------------------------------------------------
   always_comb begin
      w_rs1_busy = r_sb[rs1_addr];
      w_rs2_busy = r_sb[rs2_addr];
`ifdef GPR_WB_EARLY_CLEAR_EN
      if (r_wb_wen && (r_wb_addr == rs1_addr)) begin
         w_rs1_busy = w_iss_set && (iss_rd == rs1_addr);
      end
      if (r_wb_wen && (r_wb_addr == rs2_addr)) begin
         w_rs2_busy = w_iss_set && (iss_rd == rs2_addr);
      end
`else
      // Registered scoreboard only; the write cycle still reads as busy.
`endif
   end

   assign rs1_busy = w_rs1_busy;
   assign rs2_busy = w_rs2_busy;

endmodule
`default_nettype wire

// File: tb/tb_gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpr_wb_arbiter
//  Purpose  : Directed self-checking bench for gpr_wb_arbiter. Inputs change
//             and outputs are sampled 1 ns after the rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gpr_wb_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;

`ifdef GPR_WB_EARLY_CLEAR_EN
   localparam logic c_EARLY = 1'b1;
`else
   localparam logic c_EARLY = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          iss_valid;
   logic [AW-1:0] iss_rd;
   logic          req0_valid;
   logic [AW-1:0] req0_rd;
   logic [DW-1:0] req0_data;
   logic          req0_ready;
   logic          req1_valid;
   logic [AW-1:0] req1_rd;
   logic [DW-1:0] req1_data;
   logic          req1_ready;
   logic          wb_wen;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic [AW-1:0] rs1_addr;
   logic [AW-1:0] rs2_addr;
   logic          rs1_busy;
   logic          rs2_busy;

   int n_checks;
   int n_errors;

   gpr_wb_arbiter #(.DW(DW), .AW(AW), .NREGS(32)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .iss_valid  (iss_valid),
      .iss_rd     (iss_rd),
      .req0_valid (req0_valid),
      .req0_rd    (req0_rd),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_rd    (req1_rd),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .wb_wen     (wb_wen),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .rs1_addr   (rs1_addr),
      .rs2_addr   (rs2_addr),
      .rs1_busy   (rs1_busy),
      .rs2_busy   (rs2_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance one clock; return 1 ns after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after an input change.
   task automatic settle();
      #1;
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      rst        = 1'b0;
      iss_valid  = 1'b0;
      iss_rd     = '0;
      req0_valid = 1'b0;
      req0_rd    = '0;
      req0_data  = '0;
      req1_valid = 1'b0;
      req1_rd    = '0;
      req1_data  = '0;
      rs1_addr   = '0;
      rs2_addr   = '0;

      // ---------------- reset state ----------------
      cyc();
      cyc();
      check("rst_wen",  {31'd0, wb_wen},  32'd0);
      check("rst_addr", {27'd0, wb_addr}, 32'd0);
      check("rst_data", wb_data,          32'd0);
      check("rst_rdy",  {30'd0, req0_ready, req1_ready}, 32'd0);
      rst = 1'b1;
      cyc();

      // ---------------- single EXU write ----------------
      iss_valid = 1'b1; iss_rd = 5'd5; rs1_addr = 5'd5;
      settle();
      check("exu_busy_pre", {31'd0, rs1_busy}, 32'd0);
      cyc();
      iss_valid = 1'b0;
      req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hDEADBEEF;
      settle();
      check("exu_busy_set", {31'd0, rs1_busy}, 32'd1);
      check("exu_ready",    {30'd0, req0_ready, req1_ready}, 32'd2);
      cyc();
      req0_valid = 1'b0;
      settle();
      check("exu_wen",  {31'd0, wb_wen},  32'd1);
      check("exu_addr", {27'd0, wb_addr}, 32'd5);
      check("exu_data", wb_data,          32'hDEADBEEF);
      check("exu_busy_wb", {31'd0, rs1_busy}, c_EARLY ? 32'd0 : 32'd1);
      cyc();
      check("exu_wen_pulse", {31'd0, wb_wen}, 32'd0);
      check("exu_busy_clr",  {31'd0, rs1_busy}, 32'd0);
      check("exu_data_hold", wb_data, 32'hDEADBEEF);

      // ---------------- x0 drop (rr_last was 0, now goes to 1) ----------------
      req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'h1234;
      settle();
      check("x0_ready", {30'd0, req0_ready, req1_ready}, 32'd1);
      cyc();
      req1_valid = 1'b0;
      settle();
      check("x0_wen",  {31'd0, wb_wen}, 32'd0);
      check("x0_data", wb_data, 32'h1234);
      // issue to x0 never marks it busy
      iss_valid = 1'b1; iss_rd = 5'd0; rs1_addr = 5'd0;
      cyc();
      iss_valid = 1'b0;
      settle();
      check("x0_busy", {31'd0, rs1_busy}, 32'd0);

      // ---------------- contention: 0,1,0,1 ----------------
      req0_valid = 1'b1; req0_rd = 5'd1; req0_data = 32'h11;
      req1_valid = 1'b1; req1_rd = 5'd2; req1_data = 32'h22;
      for (int i = 0; i < 4; i++) begin
         settle();
         check("cont_ready", {30'd0, req0_ready, req1_ready}, (i % 2 == 0) ? 32'd2 : 32'd1);
         cyc();
         check("cont_wen",  {31'd0, wb_wen},  32'd1);
         check("cont_addr", {27'd0, wb_addr}, (i % 2 == 0) ? 32'd1 : 32'd2);
         check("cont_data", wb_data,          (i % 2 == 0) ? 32'h11 : 32'h22);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      cyc();

      // ---------------- set/clear collision on r7 ----------------
      iss_valid = 1'b1; iss_rd = 5'd7; rs2_addr = 5'd7;
      cyc();
      iss_valid = 1'b0;
      req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h77;
      cyc();
      req0_valid = 1'b0;
      iss_valid = 1'b1; iss_rd = 5'd7;
      settle();
      check("coll_wen",  {31'd0, wb_wen}, 32'd1);
      check("coll_busy_now", {31'd0, rs2_busy}, 32'd1);
      cyc();
      iss_valid = 1'b0;
      settle();
      check("coll_busy_after", {31'd0, rs2_busy}, 32'd1);
      req0_valid = 1'b1;
      cyc();
      req0_valid = 1'b0;
      cyc();
      check("coll_busy_clr", {31'd0, rs2_busy}, 32'd0);

      // ---------------- async reset mid-operation ----------------
      iss_valid = 1'b1; iss_rd = 5'd3;
      cyc();
      iss_rd = 5'd9;
      cyc();
      iss_valid = 1'b0;
      req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h33;
      rs1_addr = 5'd3; rs2_addr = 5'd9;
      cyc();
      req0_valid = 1'b0;
      settle();
      check("ar_wen_pre",  {31'd0, wb_wen},   32'd1);
      check("ar_busy_pre", {31'd0, rs2_busy}, 32'd1);
      #1;
      rst = 1'b0;
      #1;
      check("ar_wen",   {31'd0, wb_wen},   32'd0);
      check("ar_busy1", {31'd0, rs1_busy}, 32'd0);
      check("ar_busy2", {31'd0, rs2_busy}, 32'd0);
      check("ar_addr",  {27'd0, wb_addr},  32'd0);
      cyc();
      rst = 1'b1;
      req0_valid = 1'b1; req0_rd = 5'd4; req0_data = 32'h44;
      req1_valid = 1'b1; req1_rd = 5'd6; req1_data = 32'h66;
      settle();
      check("ar_first_grant", {30'd0, req0_ready, req1_ready}, 32'd2);
      cyc();
      req0_valid = 1'b0; req1_valid = 1'b0;
      check("ar_first_addr", {27'd0, wb_addr}, 32'd4);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
